// File: rtl/param_calculator_core.sv
// Keyboard calculator core: two N-digit BCD operands entered from one-pulse key
// events, sequential add/sub/shift-add multiply, double-dabble back to BCD, and a
// time-multiplexed 2N-digit seven-segment display.
//
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero result digits
// in the SHOW state (least significant digit always shown).
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   key_pulse/key_code  one-cycle key strobe; 0-9 digit, 10 '+', 11 '-', 12 '*', 13 '=', 14 clear
//   busy                high while arithmetic or BCD conversion runs
//   done                one-cycle pulse on entry to SHOW
//   minus               result negative (subtract with A<B)
//   result_bcd          result magnitude, BCD, MS digit at top
//   ssd_ctrl            digit enables, active-low, MSB = leftmost digit
//   show                segments {dp,g..a}, active-low
module param_calculator_core #(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned SCAN_DIV = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_pulse,
  input  logic [4:0]            key_code,
  output logic                  busy,
  output logic                  done,
  output logic                  minus,
  output logic [8*DIGITS-1:0]   result_bcd,
  output logic [2*DIGITS-1:0]   ssd_ctrl,
  output logic [7:0]            show
);

  localparam int unsigned AW = 4 * DIGITS;     // operand binary / BCD width
  localparam int unsigned RW = 2 * AW;         // result binary width
  localparam int unsigned BW = 8 * DIGITS;     // result BCD width
  localparam int unsigned DW = 2 * DIGITS;     // display digits
  localparam int unsigned CW = $clog2(RW);
  localparam int unsigned SW = $clog2(DW);

  typedef enum logic [2:0] {
    ST_ENTRY_A = 3'd0,
    ST_ENTRY_B = 3'd1,
    ST_ARITH   = 3'd2,
    ST_CONV    = 3'd3,
    ST_SHOW    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_t;

  // BCD operand to binary, MS digit first
  function automatic logic [AW-1:0] bcd2bin(input logic [AW-1:0] bcd);
    logic [AW-1:0] v;
    v = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--)
      v = AW'(v * AW'(10)) + AW'(bcd[4*i +: 4]);
    return v;
  endfunction

  // Double-dabble correction: add 3 to every digit >= 5
  function automatic logic [BW-1:0] dd_adjust(input logic [BW-1:0] x);
    logic [BW-1:0] y;
    y = x;
    for (int i = 0; i < int'(DW); i++)
      if (x[4*i +: 4] >= 4'd5) y[4*i +: 4] = x[4*i +: 4] + 4'd3;
    return y;
  endfunction

  // Active-low {dp,g..a}; anything non-BCD blanks the digit
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Bit i set when digit i and every digit above it are zero; digit 0 never set
  function automatic logic [DW-1:0] lead_zero(input logic [BW-1:0] x);
    logic [DW-1:0] m;
    logic          z;
    m = '0;
    z = 1'b1;
    for (int i = int'(DW) - 1; i > 0; i--) begin
      z    = z && (x[4*i +: 4] == 4'd0);
      m[i] = z;
    end
    return m;
  endfunction
`endif

  state_t               state, state_n;
  op_t                  op;
  logic [AW-1:0]        a, b;
  logic [AW-1:0]        a_bin, b_bin, abs_diff, mplier;
  logic [RW-1:0]        prod, mcand, prod_step, bin_sr;
  logic [BW-1:0]        bcd_sr, bcd_adj, conv_bcd_n, disp_val;
  logic [CW-1:0]        cnt;
  logic [SCAN_DIV-1:0]  pre;
  logic [SW-1:0]        scan_idx;
  logic [3:0]           disp_digit;
  logic [7:0]           show_c;
  logic                 key_dig, key_op, key_eq, key_clr;
  logic                 a_lt_b, arith_last, conv_last, busy_n, done_n;

  // Key decode
  assign key_dig = key_pulse && (key_code <= 5'd9);
  assign key_op  = key_pulse && (key_code >= 5'd10) && (key_code <= 5'd12);
  assign key_eq  = key_pulse && (key_code == 5'd13);
  assign key_clr = key_pulse && (key_code == 5'd14);

  // Datapath helpers
  assign a_bin      = bcd2bin(a);
  assign b_bin      = bcd2bin(b);
  assign a_lt_b     = a_bin < b_bin;
  assign abs_diff   = a_lt_b ? (b_bin - a_bin) : (a_bin - b_bin);
  assign prod_step  = prod + (mplier[0] ? mcand : '0);
  assign bcd_adj    = dd_adjust(bcd_sr);
  assign conv_bcd_n = BW'({bcd_adj, bin_sr[RW-1]});
  assign arith_last = (op != OP_MUL) || (cnt == CW'(AW - 1));
  assign conv_last  = (cnt == CW'(RW - 1));

  // Next-state and registered-output decode
  always_comb begin
    state_n = state;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    if (key_clr) begin
      state_n = ST_ENTRY_A;
    end else begin
      case (state)
        ST_ENTRY_A: if (key_op)     state_n = ST_ENTRY_B;
        ST_ENTRY_B: if (key_eq)     state_n = ST_ARITH;
        ST_ARITH:   if (arith_last) state_n = ST_CONV;
        ST_CONV:    if (conv_last)  state_n = ST_SHOW;
        ST_SHOW:    if (key_dig)    state_n = ST_ENTRY_A;
        default:                    state_n = ST_ENTRY_A;
      endcase
    end
    busy_n = (state_n == ST_ARITH) || (state_n == ST_CONV);
    done_n = (state == ST_CONV) && (state_n == ST_SHOW);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_ENTRY_A;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Operand entry, arithmetic and BCD conversion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a          <= '0;
      b          <= '0;
      op         <= OP_ADD;
      minus      <= 1'b0;
      result_bcd <= '0;
      prod       <= '0;
      mcand      <= '0;
      mplier     <= '0;
      bin_sr     <= '0;
      bcd_sr     <= '0;
      cnt        <= '0;
    end else if (key_clr) begin
      a          <= '0;
      b          <= '0;
      minus      <= 1'b0;
      result_bcd <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        ST_ENTRY_A: begin
          if (key_dig) a <= AW'({a, key_code[3:0]});
          if (key_op) begin
            case (key_code)
              5'd10:   op <= OP_ADD;
              5'd11:   op <= OP_SUB;
              default: op <= OP_MUL;
            endcase
          end
        end
        ST_ENTRY_B: begin
          if (key_dig) b <= AW'({b, key_code[3:0]});
          if (key_eq) begin
            prod   <= '0;
            mcand  <= RW'(a_bin);
            mplier <= b_bin;
            cnt    <= '0;
          end
        end
        ST_ARITH: begin
          bcd_sr <= '0;
          case (op)
            OP_ADD: begin
              bin_sr <= RW'(a_bin) + RW'(b_bin);
              minus  <= 1'b0;
              cnt    <= '0;
            end
            OP_SUB: begin
              bin_sr <= RW'(abs_diff);
              minus  <= a_lt_b;
              cnt    <= '0;
            end
            default: begin
              // Shift-add, multiplier LSB first
              prod   <= prod_step;
              mcand  <= {mcand[RW-2:0], 1'b0};
              mplier <= {1'b0, mplier[AW-1:1]};
              minus  <= 1'b0;
              bin_sr <= prod_step;
              cnt    <= arith_last ? '0 : cnt + CW'(1);
            end
          endcase
        end
        ST_CONV: begin
          bcd_sr <= conv_bcd_n;
          bin_sr <= {bin_sr[RW-2:0], 1'b0};
          cnt    <= cnt + CW'(1);
          if (conv_last) result_bcd <= conv_bcd_n;
        end
        ST_SHOW: begin
          if (key_dig) begin
            a     <= AW'(key_code[3:0]);
            b     <= '0;
            minus <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Display source digit and segment pattern
  always_comb begin
    disp_val   = (state == ST_SHOW) ? result_bcd : {a, b};
    disp_digit = disp_val[{scan_idx, 2'b00} +: 4];
    show_c     = seg7(disp_digit);
`ifdef LEADING_ZERO_BLANK_EN
    if ((state == ST_SHOW) && lead_zero(result_bcd)[scan_idx]) show_c = 8'hFF;
`endif
  end

  // Scan prescaler and digit multiplexer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre      <= '0;
      scan_idx <= '0;
      ssd_ctrl <= ~DW'(1);
      show     <= 8'hC0;
    end else begin
      pre <= pre + SCAN_DIV'(1);
      if (&pre) scan_idx <= (scan_idx == SW'(DW - 1)) ? '0 : scan_idx + SW'(1);
      ssd_ctrl <= ~(DW'(1) << scan_idx);
      show     <= show_c;
    end
  end

endmodule
